// File: rtl/frame_test_sequencer.sv
// Frame test sequencer: injects an LFSR pixel frame, drains the pipeline, then compares the signature; FRAME_TEST_SEQ_TIMEOUT_EN adds a DRAIN watchdog.
// Latency: first px_rdy_o strobe two edges after an accepted start; verdict (done_o/pass_o) two edges after drain completes.
// Backpressure: none; px_rdy_o is a push strobe and px_rdy_i is only counted, never stalled.
module frame_test_sequencer #(
    parameter int CNT_W     = 16,
    parameter int GAP_W     = 4,
    parameter int DRAIN_MAX = 1023
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] frame_len_i,
    input  logic [CNT_W-1:0] out_len_i,
    input  logic [GAP_W-1:0] gap_i,
    input  logic [23:0]      seed_i,
    input  logic [23:0]      golden_i,
    output logic [23:0]      px_data_o,
    output logic             px_rdy_o,
    input  logic             px_rdy_i,
    input  logic [23:0]      sig_i,
    output logic             sa_clear_o,
    output logic             sa_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_INJECT, S_GAP, S_DRAIN, S_CHECK, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] frame_len_q, out_len_q, in_cnt_q, out_cnt_q;
    logic [GAP_W-1:0] gap_q, gap_cnt_q;
    logic [23:0]      lfsr_q, lfsr_nxt, px_hold_q;
    logic             pass_q;
    logic             start_ok, last_px, gap_end, drain_ok, counting, wd_hit;

    assign start_ok = start_i && !abort_i && (state_q == S_IDLE || state_q == S_DONE);
    assign last_px  = (in_cnt_q == frame_len_q - CNT_W'(1));
    assign gap_end  = (gap_cnt_q == gap_q - GAP_W'(1));
    assign drain_ok = (out_cnt_q == out_len_q) && (in_cnt_q == frame_len_q);
    assign counting = (state_q == S_INJECT) || (state_q == S_GAP) || (state_q == S_DRAIN);
    assign lfsr_nxt = {lfsr_q[22:0], lfsr_q[23] ^ lfsr_q[22] ^ lfsr_q[21] ^ lfsr_q[16]};

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (start_i) state_d = S_CLEAR;
                S_CLEAR:        state_d = (frame_len_q != '0) ? S_INJECT : S_DRAIN;
                S_INJECT: begin
                    if (last_px)            state_d = S_DRAIN;
                    else if (gap_q != '0)   state_d = S_GAP;
                    else                    state_d = S_INJECT;
                end
                S_GAP:          if (gap_end) state_d = S_INJECT;
                S_DRAIN:        if (drain_ok || wd_hit) state_d = S_CHECK;
                S_CHECK:        state_d = S_DONE;
                default:        state_d = S_IDLE;
            endcase
        end
    end

    // Abort silences the strobes in the cycle it is raised, not just from the next one.
    always_comb begin
        px_rdy_o   = 1'b0;
        sa_clear_o = 1'b0;
        sa_en_o    = 1'b0;
        done_o     = 1'b0;
        busy_o     = (state_q != S_IDLE) && (state_q != S_DONE);
        if (!abort_i) begin
            case (state_q)
                S_CLEAR:  sa_clear_o = 1'b1;
                S_INJECT: begin
                    px_rdy_o = 1'b1;
                    sa_en_o  = 1'b1;
                end
                S_GAP, S_DRAIN: sa_en_o = 1'b1;
                S_DONE:   done_o = 1'b1;
                default:  ;
            endcase
        end
    end

    assign px_data_o = px_rdy_o ? lfsr_q : px_hold_q;
    assign pass_o    = pass_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            frame_len_q <= '0;
            out_len_q   <= '0;
            gap_q       <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            lfsr_q      <= 24'h000001;
            px_hold_q   <= '0;
            pass_q      <= 1'b0;
        end else if (abort_i) begin
            pass_q <= 1'b0;
        end else begin
            if (start_ok) begin
                frame_len_q <= frame_len_i;
                out_len_q   <= out_len_i;
                gap_q       <= gap_i;
                lfsr_q      <= (seed_i == '0) ? 24'h000001 : seed_i;
                in_cnt_q    <= '0;
                out_cnt_q   <= '0;
                gap_cnt_q   <= '0;
                pass_q      <= 1'b0;
            end
            case (state_q)
                S_INJECT: begin
                    lfsr_q    <= lfsr_nxt;
                    px_hold_q <= lfsr_q;
                    in_cnt_q  <= in_cnt_q + CNT_W'(1);
                    gap_cnt_q <= '0;
                end
                S_GAP:   gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                S_CHECK: pass_q    <= (sig_i == golden_i) && !timeout_o;
                default: ;
            endcase
            // out_cnt saturates at out_len so late strobes cannot disturb the drain compare.
            if (counting && px_rdy_i && (out_cnt_q != out_len_q))
                out_cnt_q <= out_cnt_q + CNT_W'(1);
        end
    end

`ifdef FRAME_TEST_SEQ_TIMEOUT_EN
    localparam int IDLE_W = (DRAIN_MAX < 2) ? 1 : $clog2(DRAIN_MAX);

    logic [IDLE_W-1:0] idle_cnt_q;
    logic              timeout_q;

    assign wd_hit    = !px_rdy_i && (idle_cnt_q == IDLE_W'(DRAIN_MAX - 1));
    assign timeout_o = timeout_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || abort_i) begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else if (start_ok) begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else if (state_q == S_DRAIN) begin
            if (px_rdy_i)       idle_cnt_q <= '0;
            else if (!wd_hit)   idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
            if (wd_hit && !drain_ok) timeout_q <= 1'b1;
        end
    end
`else
    assign wd_hit    = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_frame_test_sequencer.sv
// Randomized self-checking bench for frame_test_sequencer against a timeline model of each run.
module tb_frame_test_sequencer;
    localparam int CNT_W     = 6;
    localparam int GAP_W     = 4;
    localparam int DRAIN_MAX = 8;

    logic             clk_i = 1'b0;
    logic             reset_i, start_i, abort_i, px_rdy_i;
    logic [CNT_W-1:0] frame_len_i, out_len_i;
    logic [GAP_W-1:0] gap_i;
    logic [23:0]      seed_i, golden_i, sig_i, px_data_o;
    logic             px_rdy_o, sa_clear_o, sa_en_o, busy_o, done_o, pass_o, timeout_o;

    int          errors = 0;
    int          checks = 0;
    logic [23:0] last_px;
    bit          pulse_sched [0:1023];

    frame_test_sequencer #(.CNT_W(CNT_W), .GAP_W(GAP_W), .DRAIN_MAX(DRAIN_MAX)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
        .frame_len_i(frame_len_i), .out_len_i(out_len_i), .gap_i(gap_i),
        .seed_i(seed_i), .golden_i(golden_i), .px_data_o(px_data_o), .px_rdy_o(px_rdy_o),
        .px_rdy_i(px_rdy_i), .sig_i(sig_i), .sa_clear_o(sa_clear_o), .sa_en_o(sa_en_o),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [23:0] lfsr_step(input logic [23:0] x);
        return {x[22:0], x[23] ^ x[22] ^ x[21] ^ x[16]};
    endfunction

    task automatic test_reset;
        logic [6:0] obs;
        reset_i = 1'b1; start_i = 1'b1; abort_i = 1'b0; px_rdy_i = 1'b1;
        frame_len_i = 6'd5; out_len_i = 6'd1; gap_i = 4'd0;
        seed_i = 24'h123456; golden_i = 24'h0; sig_i = 24'h0;
        repeat (3) @(negedge clk_i);
        obs = {px_rdy_o, sa_clear_o, sa_en_o, busy_o, done_o, pass_o, timeout_o};
        checks++;
        if (obs !== 7'b0) begin errors++; $display("FAIL reset_outputs: got %b expected 0000000", obs); end
        checks++;
        if (px_data_o !== 24'h0) begin errors++; $display("FAIL reset_px_data: got %h expected 000000", px_data_o); end
        reset_i = 1'b0; start_i = 1'b0; px_rdy_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0 || px_data_o !== 24'h0) begin
            errors++; $display("FAIL reset_idle: got busy=%b data=%h expected busy=0 data=000000", busy_o, px_data_o);
        end
        last_px = 24'h0;
    endtask

    // One complete run from IDLE/DONE; expected timeline derived from frame/gap/out rules.
    task automatic run_frame(input logic [23:0] seed, input int flen, input int olen, input int gap,
                             input logic [23:0] sig, input logic [23:0] golden, input bit noisy);
        logic [23:0] exp_px[$];
        logic [23:0] p;
        int d0, last_c, t_out, d, n, cc, k;
        bit exp_strobe, exp_pass;
        p = (seed == 24'h0) ? 24'h000001 : seed;
        for (int i = 0; i < flen; i++) begin exp_px.push_back(p); p = lfsr_step(p); end
        last_c = 1 + (flen - 1) * (gap + 1);
        d0     = (flen == 0) ? 1 : last_c + 1;
        for (int i = 0; i < 1024; i++) pulse_sched[i] = 1'b0;
        t_out = 0; n = 0; cc = $urandom_range(0, 1);
        while (n < olen + 2 && cc < 1000) begin
            pulse_sched[cc] = 1'b1;
            if (cc >= 1) begin n++; if (n == olen) t_out = cc; end
            cc += $urandom_range(1, 4);
        end
        d        = (t_out + 1 > d0) ? t_out + 1 : d0;
        exp_pass = (sig == golden);

        @(negedge clk_i);
        frame_len_i = CNT_W'(flen); out_len_i = CNT_W'(olen); gap_i = GAP_W'(gap);
        seed_i = seed; sig_i = sig; golden_i = golden; start_i = 1'b1;
        for (int c = 0; c <= d + 2; c++) begin
            @(negedge clk_i);
            exp_strobe = (flen > 0) && (c >= 1) && (c <= last_c) && ((c - 1) % (gap + 1) == 0);
            if (exp_strobe) begin k = (c - 1) / (gap + 1); last_px = exp_px[k]; end
            checks++;
            if (px_rdy_o !== exp_strobe) begin errors++; $display("FAIL px_rdy c=%0d: got %b expected %b", c, px_rdy_o, exp_strobe); end
            checks++;
            if (px_data_o !== last_px) begin errors++; $display("FAIL px_data c=%0d: got %h expected %h", c, px_data_o, last_px); end
            checks++;
            if (sa_clear_o !== (c == 0)) begin errors++; $display("FAIL sa_clear c=%0d: got %b expected %b", c, sa_clear_o, c == 0); end
            checks++;
            if (sa_en_o !== (c >= 1 && c <= d)) begin errors++; $display("FAIL sa_en c=%0d: got %b expected %b", c, sa_en_o, c >= 1 && c <= d); end
            checks++;
            if (busy_o !== (c <= d + 1)) begin errors++; $display("FAIL busy c=%0d: got %b expected %b", c, busy_o, c <= d + 1); end
            checks++;
            if (done_o !== (c == d + 2)) begin errors++; $display("FAIL done c=%0d: got %b expected %b", c, done_o, c == d + 2); end
            checks++;
            if (pass_o !== ((c == d + 2) && exp_pass)) begin
                errors++; $display("FAIL pass c=%0d: got %b expected %b", c, pass_o, (c == d + 2) && exp_pass);
            end
            checks++;
            if (timeout_o !== 1'b0) begin errors++; $display("FAIL timeout c=%0d: got %b expected 0", c, timeout_o); end
            px_rdy_i = pulse_sched[c];
            start_i  = noisy && (c == 2);
            if (noisy && c == 2) begin frame_len_i = CNT_W'($urandom); seed_i = $urandom; gap_i = 4'd0; end
        end
        px_rdy_i = 1'b0; start_i = 1'b0;
    endtask

    task automatic test_basic_sequence;
        run_frame(24'h000001, 4, 3, 0, 24'h111111, 24'h111111, 1'b0);
    endtask

    task automatic test_gap;
        run_frame(24'h00BEEF, 3, 2, 2, 24'h0, 24'h0, 1'b0);
    endtask

    task automatic test_signature;
        run_frame(24'h000033, 2, 3, 1, 24'hABCDEF, 24'hABCDEF, 1'b0);
        run_frame(24'h000033, 2, 3, 1, 24'hABCDEE, 24'hABCDEF, 1'b0);
    endtask

    task automatic test_zero_len;
        run_frame(24'h0, 0, 0, 0, 24'h5, 24'h5, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_frame(24'h0, 5, 4, 0, 24'h77, 24'h77, 1'b1);
        run_frame(24'hFEDCBA, 6, 2, 3, 24'h1, 24'h2, 1'b1);
    endtask

    task automatic test_max_len;
        run_frame(24'h800000, (1 << CNT_W) - 1, (1 << CNT_W) - 1, 0, 24'hC0FFEE, 24'hC0FFEE, 1'b0);
    endtask

    task automatic test_random;
        logic [23:0] g, s;
        for (int r = 0; r < 8; r++) begin
            g = $urandom;
            s = ($urandom_range(0, 1) == 0) ? g : g ^ (24'h1 << $urandom_range(0, 23));
            run_frame(($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom), $urandom_range(0, 12),
                      $urandom_range(0, 8), $urandom_range(0, 3), s, g, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_abort;
        logic [23:0] sd;
        @(negedge clk_i);
        frame_len_i = 6'd3; out_len_i = 6'd0; gap_i = 4'd0; start_i = 1'b1; abort_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0; abort_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || sa_clear_o !== 1'b0 || done_o !== 1'b0) begin
            errors++; $display("FAIL abort_with_start: got busy=%b clear=%b done=%b expected 0 0 0", busy_o, sa_clear_o, done_o);
        end
        sd = 24'($urandom_range(1, 24'hFFFFFF));
        frame_len_i = 6'd20; out_len_i = 6'd1; gap_i = 4'd1; seed_i = sd; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        abort_i = 1'b1;
        #1;
        checks++;
        if (px_rdy_o !== 1'b0 || sa_en_o !== 1'b0) begin
            errors++; $display("FAIL abort_mid_inject: got px_rdy=%b sa_en=%b expected 0 0", px_rdy_o, sa_en_o);
        end
        @(negedge clk_i);
        abort_i = 1'b0;
        last_px = sd;
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (px_rdy_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0 || pass_o !== 1'b0 || px_data_o !== last_px) begin
                errors++;
                $display("FAIL abort_after c=%0d: got rdy=%b done=%b busy=%b pass=%b data=%h expected 0 0 0 0 %h",
                         c, px_rdy_o, done_o, busy_o, pass_o, px_data_o, last_px);
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset_midrun;
        @(negedge clk_i);
        frame_len_i = 6'd8; out_len_i = 6'd2; gap_i = 4'd2; seed_i = 24'h0ABCDE; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        last_px = 24'h0;
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (px_rdy_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0 || px_data_o !== 24'h0) begin
                errors++;
                $display("FAIL reset_midrun c=%0d: got rdy=%b done=%b busy=%b data=%h expected 0 0 0 000000",
                         c, px_rdy_o, done_o, busy_o, px_data_o);
            end
            px_rdy_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
        end
        px_rdy_i = 1'b0;
    endtask

    task automatic test_timeout;
        @(negedge clk_i);
        frame_len_i = 6'd2; out_len_i = 6'd5; gap_i = 4'd0; seed_i = 24'h000005;
        sig_i = 24'h123; golden_i = 24'h123; start_i = 1'b1;
`ifdef FRAME_TEST_SEQ_TIMEOUT_EN
        // Drain starts at c=3; DRAIN_MAX idle cycles end at c=10, so CHECK c=11 and DONE c=12.
        for (int c = 0; c <= 3 + DRAIN_MAX - 1 + 2; c++) begin
            @(negedge clk_i);
            checks++;
            if (done_o !== (c == 12) || timeout_o !== (c >= 11) || pass_o !== 1'b0) begin
                errors++;
                $display("FAIL timeout c=%0d: got done=%b timeout=%b pass=%b expected %b %b 0",
                         c, done_o, timeout_o, pass_o, c == 12, c >= 11);
            end
            px_rdy_i = (c == 1 || c == 2);
            start_i  = 1'b0;
        end
`else
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk_i);
            checks++;
            if (done_o !== 1'b0 || timeout_o !== 1'b0 || (c >= 1 && busy_o !== 1'b1)) begin
                errors++;
                $display("FAIL drain_wait c=%0d: got done=%b timeout=%b busy=%b expected 0 0 1", c, done_o, timeout_o, busy_o);
            end
            px_rdy_i = (c == 1 || c == 2);
            start_i  = 1'b0;
        end
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL drain_abort: got busy=%b expected 0", busy_o); end
`endif
        px_rdy_i = 1'b0;
        last_px  = lfsr_step(24'h000005);
    endtask

    initial begin
        test_reset;
        test_basic_sequence;
        test_gap;
        test_signature;
        test_zero_len;
        test_back_to_back;
        test_max_len;
        test_random;
        test_abort;
        test_reset_midrun;
        test_timeout;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/frame_test_sequencer.md
FRAME_TEST_SEQUENCER -- requirements
Module: frame_test_sequencer

Interface
REQ-001 Parameter CNT_W, default 16, width of frame/output pixel counts.
REQ-002 Parameter GAP_W, default 4, width of inter-pixel gap count.
REQ-003 Parameter DRAIN_MAX, default 1023, idle cycles tolerated in DRAIN before timeout.
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 reset_i  in  1  synchronous, active-high reset.
REQ-006 start_i  in  1  pulse; begins a test run from IDLE or DONE.
REQ-007 abort_i  in  1  level; forces IDLE.
REQ-008 frame_len_i  in  CNT_W  pixels to inject; latched on accepted start.
REQ-009 out_len_i  in  CNT_W  expected pipeline output strobes; latched on accepted start.
REQ-010 gap_i  in  GAP_W  idle cycles between injected pixels; latched on accepted start.
REQ-011 seed_i  in  24  LFSR seed; latched on accepted start.
REQ-012 golden_i  in  24  expected signature; sampled in CHECK.
REQ-013 px_data_o  out  24  injected pixel to the gray/sobel pipeline.
REQ-014 px_rdy_o  out  1  one-cycle strobe qualifying px_data_o.
REQ-015 px_rdy_i  in  1  pipeline output-pixel strobe.
REQ-016 sig_i  in  24  signature analyzer output.
REQ-017 sa_clear_o  out  1  signature analyzer clear.
REQ-018 sa_en_o  out  1  signature analyzer enable.
REQ-019 busy_o, done_o, pass_o, timeout_o  out  1 each  status.

Function
REQ-020 FSM states IDLE, CLEAR, INJECT, GAP, DRAIN, CHECK, DONE.
REQ-021 IDLE/DONE + start_i -> CLEAR; latch frame_len/out_len/gap/seed; clear pass_o, timeout_o, counters.
REQ-022 CLEAR lasts exactly 1 cycle, sa_clear_o=1; next INJECT if frame_len>0, else DRAIN.
REQ-023 INJECT: px_rdy_o=1 one cycle, px_data_o=LFSR state, LFSR advances, in_cnt+1; next GAP if gap>0 else INJECT; after in_cnt reaches frame_len -> DRAIN.
REQ-024 GAP holds px_rdy_o=0 for exactly gap cycles, then INJECT.
REQ-025 LFSR: 24-bit Fibonacci, shift left, bit0 = b23^b22^b21^b16; seed 0 loaded as 24'h000001; first injected pixel = seed.
REQ-026 sa_en_o=1 in INJECT, GAP, DRAIN; 0 elsewhere.
REQ-027 out_cnt increments on px_rdy_i in INJECT/GAP/DRAIN, saturates at out_len; px_rdy_i ignored in IDLE/CLEAR/CHECK/DONE.
REQ-028 DRAIN -> CHECK when out_cnt==out_len and in_cnt==frame_len (out_len=0 exits next cycle).
REQ-029 CHECK lasts 1 cycle: pass_o<=(sig_i==golden_i) and !timeout; -> DONE.
REQ-030 DONE: done_o=1, pass_o/timeout_o held until next accepted start or reset.
REQ-031 busy_o=1 in CLEAR through CHECK.
REQ-032 start_i while busy ignored.
REQ-033 abort_i beats start_i and all transitions: next state IDLE, px_rdy_o/sa_en_o/sa_clear_o=0, done_o=0, pass_o=0.
REQ-034 Counters CNT_W bits, no wrap: frame_len=2^CNT_W-1 fully injected.
REQ-035 px_data_o holds last injected value between strobes.

Reset
REQ-036 reset_i synchronous active-high; state IDLE, all outputs 0, px_data_o=0, LFSR=24'h000001.
REQ-037 Reset mid-run discards run; no done_o pulse.

Configuration
REQ-038 Macro FRAME_TEST_SEQ_TIMEOUT_EN defined: DRAIN counts consecutive cycles without px_rdy_i; on reaching DRAIN_MAX sets timeout_o=1 -> CHECK (pass_o forced 0); counter resets on each px_rdy_i.
REQ-039 Macro undefined: no watchdog, DRAIN waits indefinitely, timeout_o tied 0.

Verification
REQ-040 seed=1, frame_len=4, gap=0 -> px_rdy_o 4 consecutive cycles, px_data_o 000001,000002,000004,000008.
REQ-041 frame_len=3, gap=2 -> strobes exactly 3 cycles apart; sa_clear_o one cycle before first strobe.
REQ-042 out_len=3, 3 px_rdy_i, sig_i=golden_i=24'hABCDEF -> done_o=1, pass_o=1; sig_i=24'hABCDEE -> pass_o=0.
REQ-043 abort_i asserted with start_i, and mid-INJECT -> IDLE next cycle, no further strobes, done_o=0.
REQ-044 TIMEOUT_EN, DRAIN_MAX=8, out_len=5, only 2 px_rdy_i -> timeout_o=1, pass_o=0, done_o=1 after 8 idle cycles.
REQ-045 frame_len=0, out_len=0 -> CLEAR, DRAIN, CHECK, DONE in 4 cycles, zero px_rdy_o strobes.
